// File: rtl/spi_fifo_ctrl.sv
// spi_fifo_ctrl: SPI push/pull FIFO, req/ack write port and
// req/resp/ack read port, with level thresholds and sticky status.
//
// Ports:
//   clk_i, arst_n_i      clock, async active-low reset
//   soft_rst_i           sync reset, same effect as arst_n_i
//   allow_overwrite_i    full write discards the oldest entry
//   clear_flags_i        clears sticky flags (set wins)
//   req_a_i, data_a_i    write request/data, held until ack_a_o
//   ack_a_o              one-cycle write acknowledge
//   req_b_i              read request
//   data_b_o, resp_b_o   read data/response, held until ack_b_i
//   rd_empty_o           response came from an empty FIFO
//   ack_b_i              read acknowledge, pops the entry
//   fifo_occupancy_o     zero-extended occupancy
//   fifo_full_o, fifo_empty_o, almost_full_o, almost_empty_o
//   overflow_o, overrun_o, underflow_o   sticky status
module spi_fifo_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_ADDR  = 4,
  parameter int REG_WIDTH  = 16,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  soft_rst_i,
  input  logic                  allow_overwrite_i,
  input  logic                  clear_flags_i,
  input  logic                  req_a_i,
  input  logic [DATA_WIDTH-1:0] data_a_i,
  output logic                  ack_a_o,
  input  logic                  req_b_i,
  output logic [DATA_WIDTH-1:0] data_b_o,
  output logic                  resp_b_o,
  output logic                  rd_empty_o,
  input  logic                  ack_b_i,
  output logic [REG_WIDTH-1:0]  fifo_occupancy_o,
  output logic                  fifo_full_o,
  output logic                  fifo_empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic                  overflow_o,
  output logic                  overrun_o,
  output logic                  underflow_o
);

  localparam int FIFO_DEPTH = 2 ** FIFO_ADDR;
  localparam int OCC_W = FIFO_ADDR + 1;

  typedef logic [OCC_W-1:0]     occ_t;
  typedef logic [FIFO_ADDR-1:0] ptr_t;

  localparam occ_t OCC_FULL = occ_t'(FIFO_DEPTH);
  localparam occ_t AF_LVL   = occ_t'(AF_LEVEL);
  localparam occ_t AE_LVL   = occ_t'(AE_LEVEL);
  localparam occ_t OCC_ONE  = occ_t'(1);
  localparam ptr_t PTR_ONE  = ptr_t'(1);

  typedef enum logic {
    WR_IDLE,
    WR_ACK
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_t;

  wr_state_t wr_state_q;
  rd_state_t rd_state_q;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  ptr_t head_q;
  ptr_t tail_q;
  occ_t occ_q;
  occ_t occ_d;

  logic full;
  logic empty;
  logic rd_start;
  logic pop;
  logic head_lock;
  logic overwrite_ok;
  logic wr_req;
  logic space;
  logic wr_acc;
  logic ovr_evt;
  logic ovf_evt;
  logic unf_evt;

  assign full  = (occ_q == OCC_FULL);
  assign empty = (occ_q == '0);

  assign rd_start = (rd_state_q == RD_IDLE) && req_b_i;

  // Only a non-empty response removes an entry.
  assign pop = (rd_state_q == RD_RESP) && ack_b_i
             && !rd_empty_o;

  // The head is locked from the cycle a read samples it until
  // the pop, so an overwrite cannot discard the entry in flight.
  assign head_lock    = resp_b_o || rd_start;
  assign overwrite_ok = allow_overwrite_i && !head_lock;

  assign wr_req  = (wr_state_q == WR_IDLE) && req_a_i;
  assign space   = !full || pop;
  assign wr_acc  = wr_req && (space || overwrite_ok);
  assign ovr_evt = wr_acc && full && !pop;
  assign ovf_evt = wr_req && !wr_acc;
  assign unf_evt = rd_start && empty;

  always_comb begin
    occ_d = occ_q;
    unique case (1'b1)
      (wr_acc && !ovr_evt && !pop): occ_d = occ_q + OCC_ONE;
      (pop && !wr_acc):             occ_d = occ_q - OCC_ONE;
      default:                      occ_d = occ_q;
    endcase
  end

  // Storage is not reset; contents are undefined after reset.
  always_ff @(posedge clk_i) begin
    if (wr_acc && !soft_rst_i) begin
      mem[tail_q] <= data_a_i;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else if (soft_rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      occ_q <= occ_d;
      if (wr_acc) begin
        tail_q <= tail_q + PTR_ONE;
      end
      if (pop || ovr_evt) begin
        head_q <= head_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_state_q <= WR_IDLE;
      ack_a_o    <= 1'b0;
    end else if (soft_rst_i) begin
      wr_state_q <= WR_IDLE;
      ack_a_o    <= 1'b0;
    end else begin
      unique case (wr_state_q)
        WR_IDLE: begin
          ack_a_o <= wr_acc;
          if (wr_acc) begin
            wr_state_q <= WR_ACK;
          end
        end
        WR_ACK: begin
          ack_a_o    <= 1'b0;
          wr_state_q <= WR_IDLE;
        end
        default: begin
          ack_a_o    <= 1'b0;
          wr_state_q <= WR_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rd_state_q <= RD_IDLE;
      resp_b_o   <= 1'b0;
      rd_empty_o <= 1'b0;
      data_b_o   <= '0;
    end else if (soft_rst_i) begin
      rd_state_q <= RD_IDLE;
      resp_b_o   <= 1'b0;
      rd_empty_o <= 1'b0;
      data_b_o   <= '0;
    end else begin
      unique case (rd_state_q)
        RD_IDLE: begin
          if (req_b_i) begin
            rd_state_q <= RD_RESP;
            resp_b_o   <= 1'b1;
            rd_empty_o <= empty;
            data_b_o   <= empty ? '0 : mem[head_q];
          end
        end
        RD_RESP: begin
          if (ack_b_i) begin
            rd_state_q <= RD_IDLE;
            resp_b_o   <= 1'b0;
            rd_empty_o <= 1'b0;
          end
        end
        default: begin
          rd_state_q <= RD_IDLE;
          resp_b_o   <= 1'b0;
          rd_empty_o <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      overflow_o  <= 1'b0;
      overrun_o   <= 1'b0;
      underflow_o <= 1'b0;
    end else if (soft_rst_i) begin
      overflow_o  <= 1'b0;
      overrun_o   <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      overflow_o  <= ovf_evt
                   || (overflow_o && !clear_flags_i);
      overrun_o   <= ovr_evt
                   || (overrun_o && !clear_flags_i);
      underflow_o <= unf_evt
                   || (underflow_o && !clear_flags_i);
    end
  end

  assign fifo_occupancy_o = REG_WIDTH'(occ_q);
  assign fifo_full_o      = full;
  assign fifo_empty_o     = empty;
  assign almost_full_o    = (occ_q >= AF_LVL);
  assign almost_empty_o   = (occ_q <= AE_LVL);

endmodule

// File: tb/tb_spi_fifo_ctrl.sv
// tb_spi_fifo_ctrl: directed bench for spi_fifo_ctrl with
// hand-computed expectations.
module tb_spi_fifo_ctrl;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        soft_rst = 1'b0;
  logic        allow_ow = 1'b0;
  logic        clr = 1'b0;
  logic        req_a = 1'b0;
  logic [15:0] data_a = '0;
  logic        ack_a;
  logic        req_b = 1'b0;
  logic [15:0] data_b;
  logic        resp_b;
  logic        rd_empty;
  logic        ack_b = 1'b0;
  logic [15:0] occ;
  logic        full;
  logic        empty;
  logic        afull;
  logic        aempty;
  logic        ovf;
  logic        ovr;
  logic        unf;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_fifo_ctrl dut (
    .clk_i             (clk),
    .arst_n_i          (arst_n),
    .soft_rst_i        (soft_rst),
    .allow_overwrite_i (allow_ow),
    .clear_flags_i     (clr),
    .req_a_i           (req_a),
    .data_a_i          (data_a),
    .ack_a_o           (ack_a),
    .req_b_i           (req_b),
    .data_b_o          (data_b),
    .resp_b_o          (resp_b),
    .rd_empty_o        (rd_empty),
    .ack_b_i           (ack_b),
    .fifo_occupancy_o  (occ),
    .fifo_full_o       (full),
    .fifo_empty_o      (empty),
    .almost_full_o     (afull),
    .almost_empty_o    (aempty),
    .overflow_o        (ovf),
    .overrun_o         (ovr),
    .underflow_o       (unf)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] d,
                          output int ack_cyc);
    logic seen;
    seen = 1'b0;
    req_a = 1'b1;
    data_a = d;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack_a) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("wr_timeout", 0, 1);
    ack_cyc = cyc;
    req_a = 1'b0;
    tick();
    chk("ack_pulse", ack_a, 0);
  endtask

  task automatic do_read(output logic [15:0] d,
                         output logic e);
    logic seen;
    seen = 1'b0;
    req_b = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (resp_b) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("rd_timeout", 0, 1);
    d = data_b;
    e = rd_empty;
    req_b = 1'b0;
    ack_b = 1'b1;
    tick();
    ack_b = 1'b0;
    chk("resp_drop", resp_b, 0);
  endtask

  task automatic soft_reset();
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
  endtask

  initial begin
    int          ac;
    int          prev;
    int          cnt;
    logic [15:0] d;
    logic        e;
    logic [15:0] exp_d;

    #23;
    chk("rst_occ", occ, 0);
    chk("rst_empty", empty, 1);
    chk("rst_aempty", aempty, 1);
    chk("rst_full", full, 0);
    chk("rst_ack", ack_a, 0);
    chk("rst_resp", resp_b, 0);
    chk("rst_flags", {ovf, ovr, unf}, 0);
    arst_n = 1'b1;
    tick();

    // 1: fill to full
    prev = 0;
    for (int k = 1; k <= 16; k++) begin
      do_write(16'(k), ac);
      if (k > 1) chk("ack_gap", ac - prev, 2);
      prev = ac;
      if (k == 4)  chk("ae_at4", aempty, 1);
      if (k == 5)  chk("ae_at5", aempty, 0);
      if (k == 11) chk("af_at11", afull, 0);
      if (k == 12) chk("af_at12", afull, 1);
    end
    chk("t1_full", full, 1);
    chk("t1_occ", occ, 16);

    // 2: stalled write on full FIFO
    allow_ow = 1'b0;
    req_a = 1'b1;
    data_a = 16'hAAAA;
    cnt = 0;
    repeat (10) begin
      tick();
      if (ack_a) cnt++;
    end
    chk("t2_no_ack", cnt, 0);
    chk("t2_ovf", ovf, 1);
    do_read(d, e);
    chk("t2_rd", d, 16'h0001);
    chk("t2_ack", ack_a, 1);
    req_a = 1'b0;
    chk("t2_occ", occ, 16);
    tick();
    chk("t2_ack_drop", ack_a, 0);

    // 3: overwrite on full FIFO
    soft_reset();
    chk("t3_rst_ovf", ovf, 0);
    chk("t3_rst_occ", occ, 0);
    for (int k = 1; k <= 16; k++) do_write(16'(k), ac);
    allow_ow = 1'b1;
    do_write(16'hBBBB, ac);
    allow_ow = 1'b0;
    chk("t3_ovr", ovr, 1);
    chk("t3_occ", occ, 16);
    for (int i = 0; i < 16; i++) begin
      exp_d = (i < 15) ? 16'(i + 2) : 16'hBBBB;
      do_read(d, e);
      chk("t3_rd", d, exp_d);
      chk("t3_rd_empty", e, 0);
    end
    chk("t3_empty", empty, 1);

    // 4: read on empty FIFO
    do_read(d, e);
    chk("t4_data", d, 0);
    chk("t4_rd_empty", e, 1);
    chk("t4_unf", unf, 1);
    chk("t4_occ", occ, 0);
    do_write(16'h1234, ac);
    do_read(d, e);
    chk("t4_ptr", d, 16'h1234);
    chk("t4_ovr_kept", ovr, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t4_clear", {ovf, ovr, unf}, 0);

    // 5: concurrent write and pop across tail wrap
    soft_reset();
    for (int i = 0; i < 8; i++) do_write(16'h00D0, ac);
    for (int i = 0; i < 8; i++) do_read(d, e);
    for (int k = 1; k <= 5; k++) do_write(16'(k), ac);
    chk("t5_occ0", occ, 5);
    for (int i = 0; i < 8; i++) begin
      req_b = 1'b1;
      tick();
      chk("t5_resp", resp_b, 1);
      chk("t5_rd", data_b, 16'(i + 1));
      req_b = 1'b0;
      ack_b = 1'b1;
      req_a = 1'b1;
      data_a = 16'(i + 6);
      tick();
      ack_b = 1'b0;
      req_a = 1'b0;
      chk("t5_ack", ack_a, 1);
      chk("t5_occ", occ, 5);
    end
    for (int i = 0; i < 5; i++) begin
      do_read(d, e);
      chk("t5_drain", d, 16'(i + 9));
    end
    chk("t5_empty", empty, 1);

    // 6: resets mid-transaction
    do_write(16'h0055, ac);
    req_b = 1'b1;
    tick();
    chk("t6_resp_up", resp_b, 1);
    req_b = 1'b0;
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    chk("t6_resp_rst", {resp_b, rd_empty}, 0);
    chk("t6_data_rst", data_b, 0);
    chk("t6_occ_rst", occ, 0);
    chk("t6_aempty", {empty, aempty}, 2'b11);

    req_a = 1'b1;
    data_a = 16'h0066;
    tick();
    chk("t6_ack_up", ack_a, 1);
    req_a = 1'b0;
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    chk("t6_ack_rst", ack_a, 0);
    chk("t6_occ_rst2", occ, 0);

    req_a = 1'b1;
    data_a = 16'h0077;
    tick();
    chk("t6_ack_up2", ack_a, 1);
    #2;
    arst_n = 1'b0;
    #1;
    chk("t6_arst_ack", ack_a, 0);
    chk("t6_arst_occ", occ, 0);
    chk("t6_arst_empty", empty, 1);
    req_a = 1'b0;
    #3;
    arst_n = 1'b1;
    tick();
    do_write(16'h00C3, ac);
    chk("t6_idx0", dut.mem[0], 16'h00C3);
    do_read(d, e);
    chk("t6_rd", d, 16'h00C3);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
